// File: rtl/demux8_1_buf.sv
// demux8_1_buf: registered 1-to-8 demux steering one valid/ready input into eight one-entry output buffers.
// Latency: word accepted at edge k is on out_dataN/out_valid[n] in cycle k+1; no in_data-to-output comb path.
// Backpressure: in_ready = !out_valid[slt] | out_ready[slt]; a full channel stalls only words addressed to it.
// Optional feature: define DEMUX8_CNT_EN to add the 16-bit wrapping accepted-word counter on xfer_cnt.

module demux8_1_buf #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       slt,
    input  logic [width-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [width-1:0] out_data0,
    output logic [width-1:0] out_data1,
    output logic [width-1:0] out_data2,
    output logic [width-1:0] out_data3,
    output logic [width-1:0] out_data4,
    output logic [width-1:0] out_data5,
    output logic [width-1:0] out_data6,
    output logic [width-1:0] out_data7,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready
`ifdef DEMUX8_CNT_EN
    ,
    output logic [15:0]      xfer_cnt
`endif
);

    // Per-channel occupancy: each output is a single-entry buffer.
    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_t;

    ch_state_t        r_state     [8];
    ch_state_t        w_state_nxt [8];
    logic [width-1:0] r_data      [8];

    logic [7:0]       w_valid;
    logic [7:0]       w_drain;
    logic [7:0]       w_fill;
    logic             w_in_ready;
    logic             w_accept;

    // Decode occupancy, drains and the single refill target for this cycle.
    always_comb begin
        w_valid = '0;
        w_drain = '0;
        w_fill  = '0;
        for (int n = 0; n < 8; n++) begin
            w_valid[n] = (r_state[n] == CH_FULL);
        end
        // A full channel may take a new word only if its consumer empties it this cycle.
        w_in_ready = !w_valid[slt] || out_ready[slt];
        w_accept   = in_valid && w_in_ready;
        for (int n = 0; n < 8; n++) begin
            // out_ready on an empty channel is ignored.
            w_drain[n] = w_valid[n] && out_ready[n];
            w_fill[n]  = w_accept && (slt == 3'(n));
        end
    end

    // Next-state per channel; refill wins over drain so a pass-through keeps the channel full.
    always_comb begin
        for (int n = 0; n < 8; n++) begin
            w_state_nxt[n] = r_state[n];
            case (r_state[n])
                CH_EMPTY: begin
                    if (w_fill[n]) begin
                        w_state_nxt[n] = CH_FULL;
                    end
                end
                CH_FULL: begin
                    if (w_drain[n] && !w_fill[n]) begin
                        w_state_nxt[n] = CH_EMPTY;
                    end
                end
                default: begin
                    w_state_nxt[n] = CH_EMPTY;
                end
            endcase
        end
    end

    // Channel state registers; reset discards any buffered words.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int n = 0; n < 8; n++) begin
                r_state[n] <= CH_EMPTY;
            end
        end else begin
            for (int n = 0; n < 8; n++) begin
                r_state[n] <= w_state_nxt[n];
            end
        end
    end

    // Data registers load only on refill and otherwise hold their last word, even after a drain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int n = 0; n < 8; n++) begin
                r_data[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 8; n++) begin
                if (w_fill[n]) begin
                    r_data[n] <= in_data;
                end
            end
        end
    end

`ifdef DEMUX8_CNT_EN
    logic [15:0] r_xfer_cnt;

    // Count accepted words; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_xfer_cnt <= '0;
        end else if (w_accept) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = w_valid;
    assign out_data0 = r_data[0];
    assign out_data1 = r_data[1];
    assign out_data2 = r_data[2];
    assign out_data3 = r_data[3];
    assign out_data4 = r_data[4];
    assign out_data5 = r_data[5];
    assign out_data6 = r_data[6];
    assign out_data7 = r_data[7];

endmodule

// File: tb/tb_demux8_1_buf.sv
// tb_demux8_1_buf: self-checking bench for demux8_1_buf against a per-channel occupancy model.
// Inputs change just after the falling edge; outputs are compared away from the rising edge.
// Covers reset, single delivery, backpressure, pass-through refill, streaming and random traffic.

module tb_demux8_1_buf;

    logic        clk;
    logic        reset_n;
    logic [2:0]  slt;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] od [8];
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
`ifdef DEMUX8_CNT_EN
    logic [15:0] xfer_cnt;
    logic [15:0] m_cnt;
`endif

    // Reference model: which channels hold a word and what that word is.
    logic [7:0]  m_vld;
    logic [31:0] m_dat [8];

    int n_cmp;
    int n_err;

    demux8_1_buf #(.width(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .slt       (slt),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data0 (od[0]),
        .out_data1 (od[1]),
        .out_data2 (od[2]),
        .out_data3 (od[3]),
        .out_data4 (od[4]),
        .out_data5 (od[5]),
        .out_data6 (od[6]),
        .out_data7 (od[7]),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX8_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one clock using the currently driven inputs, then move to the next falling edge.
    task automatic tick();
        bit acc;
        acc = in_valid && (!m_vld[slt] || out_ready[slt]);
        if (!reset_n) begin
            m_vld = '0;
            for (int n = 0; n < 8; n++) m_dat[n] = '0;
`ifdef DEMUX8_CNT_EN
            m_cnt = '0;
`endif
        end else begin
            m_vld = m_vld & ~out_ready;
            if (acc) begin
                m_vld[slt] = 1'b1;
                m_dat[slt] = in_data;
`ifdef DEMUX8_CNT_EN
                m_cnt = m_cnt + 16'd1;
`endif
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 8'hFF;
        tick();
        tick();
        reset_n = 1'b1; out_ready = 8'h00;
        #1;
        n_cmp++;
        if (out_valid !== 8'h00) begin
            n_err++; $display("FAIL reset_out_valid: got %h want 00", out_valid);
        end
        for (int n = 0; n < 8; n++) begin
            n_cmp++;
            if (od[n] !== 32'h0) begin
                n_err++; $display("FAIL reset_out_data%0d: got %h want 0", n, od[n]);
            end
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
`ifdef DEMUX8_CNT_EN
        n_cmp++;
        if (xfer_cnt !== 16'h0) begin
            n_err++; $display("FAIL reset_xfer_cnt: got %h want 0", xfer_cnt);
        end
`endif
    endtask

    task automatic test_single();
        slt = 3'd5; in_data = 32'hDEADBEEF; in_valid = 1'b1; out_ready = 8'h00;
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 8'h20) begin
            n_err++; $display("FAIL single_valid: got %h want 20", out_valid);
        end
        n_cmp++;
        if (od[5] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL single_data5: got %h want deadbeef", od[5]);
        end
        out_ready = 8'h20;
        tick();
        out_ready = 8'h00;
        #1;
        n_cmp++;
        if (out_valid !== 8'h00) begin
            n_err++; $display("FAIL single_drain_valid: got %h want 00", out_valid);
        end
        n_cmp++;
        if (od[5] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL single_hold_data5: got %h want deadbeef", od[5]);
        end
    endtask

    task automatic test_backpressure();
        slt = 3'd2; in_data = 32'h0000_2222; in_valid = 1'b1; out_ready = 8'h00;
        tick();
        in_data = 32'h1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_in_ready_stalled: got %b want 0", in_ready);
        end
        tick();
        n_cmp++;
        if (od[2] !== 32'h0000_2222) begin
            n_err++; $display("FAIL bp_data2_kept: got %h want 00002222", od[2]);
        end
        slt = 3'd3;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_in_ready_other: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (od[3] !== 32'h1) begin
            n_err++; $display("FAIL bp_data3: got %h want 1", od[3]);
        end
        n_cmp++;
        if (out_valid !== 8'h0C) begin
            n_err++; $display("FAIL bp_valid: got %h want 0c", out_valid);
        end
    endtask

    task automatic test_passthrough();
        slt = 3'd0; in_data = 32'hA; in_valid = 1'b1; out_ready = 8'h00;
        tick();
        in_data = 32'hB; out_ready = 8'h01;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL pt_in_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0; out_ready = 8'h00;
        #1;
        n_cmp++;
        if (out_valid[0] !== 1'b1) begin
            n_err++; $display("FAIL pt_valid0: got %b want 1", out_valid[0]);
        end
        n_cmp++;
        if (od[0] !== 32'hB) begin
            n_err++; $display("FAIL pt_data0: got %h want b", od[0]);
        end
    endtask

    task automatic test_stream();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 8'h00;
        tick();
        reset_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            slt = 3'(n); in_data = 32'h100 + n; in_valid = 1'b1;
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL stream_in_ready%0d: got %b want 1", n, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 8'hFF) begin
            n_err++; $display("FAIL stream_valid: got %h want ff", out_valid);
        end
        for (int n = 0; n < 8; n++) begin
            n_cmp++;
            if (od[n] !== 32'h100 + n) begin
                n_err++; $display("FAIL stream_data%0d: got %h want %h", n, od[n], 32'h100 + n);
            end
        end
`ifdef DEMUX8_CNT_EN
        n_cmp++;
        if (xfer_cnt !== 16'd8) begin
            n_err++; $display("FAIL stream_xfer_cnt: got %0d want 8", xfer_cnt);
        end
`endif
        // A stalled channel must not accept, and reset must discard everything.
        slt = 3'd4; in_valid = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL stream_full_in_ready: got %b want 0", in_ready);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 8'h00) begin
            n_err++; $display("FAIL stream_reset_valid: got %h want 00", out_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset_n   = ($urandom_range(0, 59) != 0);
            slt       = 3'($urandom_range(0, 7));
            in_data   = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = 8'($urandom) & 8'($urandom);
            #1;
            n_cmp++;
            if (in_ready !== (!m_vld[slt] || out_ready[slt])) begin
                n_err++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, !m_vld[slt] || out_ready[slt]);
            end
            tick();
            #1;
            n_cmp++;
            if (out_valid !== m_vld) begin
                n_err++; $display("FAIL rnd_valid c%0d: got %h want %h", c, out_valid, m_vld);
            end
            for (int n = 0; n < 8; n++) begin
                n_cmp++;
                if (od[n] !== m_dat[n]) begin
                    n_err++; $display("FAIL rnd_data%0d c%0d: got %h want %h", n, c, od[n], m_dat[n]);
                end
            end
`ifdef DEMUX8_CNT_EN
            n_cmp++;
            if (xfer_cnt !== m_cnt) begin
                n_err++; $display("FAIL rnd_xfer_cnt c%0d: got %h want %h", c, xfer_cnt, m_cnt);
            end
`endif
        end
        reset_n = 1'b1; in_valid = 1'b0; out_ready = 8'h00;
    endtask

`ifdef DEMUX8_CNT_EN
    task automatic test_cnt_wrap();
        reset_n = 1'b0; in_valid = 1'b0;
        tick();
        reset_n = 1'b1; in_valid = 1'b1; out_ready = 8'hFF;
        for (int c = 0; c < 65536; c++) begin
            slt = 3'($urandom_range(0, 7));
            in_data = $urandom;
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (xfer_cnt !== 16'h0000) begin
            n_err++; $display("FAIL cnt_wrap: got %h want 0000", xfer_cnt);
        end
    endtask
`endif

    initial begin
        n_cmp = 0; n_err = 0;
        reset_n = 1'b0; slt = 3'd0; in_data = '0; in_valid = 1'b0; out_ready = 8'h00;
        m_vld = '0;
        for (int n = 0; n < 8; n++) m_dat[n] = '0;
`ifdef DEMUX8_CNT_EN
        m_cnt = '0;
`endif
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_passthrough();
        test_stream();
        test_random();
`ifdef DEMUX8_CNT_EN
        test_cnt_wrap();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux8_1_buf.md
# demux8_1_buf

Registered 1-to-8 demultiplexer with valid/ready handshaking: accepts one word per cycle from a single producer and steers it into one of eight single-entry output buffers chosen by a 3-bit select. It is the write-side counterpart of the 8:1 read-side selection mux. It feeds eight independent consumers, for example the write-back destination ports in the CPU datapath, and absorbs per-consumer backpressure without losing data.

## Interface
- `width`, 32, data word width in bits.
- `clk`  input  1  rising-edge clock; the only clock.
- `reset_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `slt`  input  3  destination channel index for the word on `in_data`.
- `in_data`  input  width  word to deliver.
- `in_valid`  input  1  producer presents a word.
- `in_ready`  output  1  block can accept the word addressed by `slt` this cycle.
- `out_data0`..`out_data7`  output  width each  buffered word for channel n.
- `out_valid`  output  8  bit n set means channel n holds a word.
- `out_ready`  input  8  bit n set means consumer n takes its word this cycle.
- `xfer_cnt`  output  16  accepted-word counter; present only with `DEMUX8_CNT_EN`.

## Operation
- Each channel n is a one-entry buffer with two states.
  - EMPTY: `out_valid[n]` = 0.
  - FULL: `out_valid[n]` = 1 and `out_dataN` holds the word.
- Input handshake:
  - `in_ready` = !`out_valid[slt]` | `out_ready[slt]`.
  - `in_ready` is combinational from `slt`, `out_valid` and `out_ready` only. It never depends on `in_valid`.
  - A word is accepted when `in_valid` & `in_ready`.
- Accept into channel `slt`:
  - `out_dataN` <= `in_data`.
  - Channel goes to FULL, or stays FULL if the consumer drains in the same cycle (pass-through refill).
- Drain:
  - Channel n drains when `out_valid[n]` & `out_ready[n]`.
  - With no refill of channel n in the same cycle, the channel goes to EMPTY.
  - `out_dataN` is not cleared on drain; it holds its last value.
- Parallel drains: any subset of channels may drain in the same cycle. At most one channel is refilled per cycle.
- Channel isolation: a stalled channel blocks only words addressed to it. Words for other channels are still accepted.
- `slt` and `in_data` are don't-care when `in_valid` = 0. Changing `slt` while a word is stalled is permitted and re-evaluates `in_ready` against the new channel.
- `out_ready[n]` while `out_valid[n]` = 0 has no effect.
- Reset (`reset_n` = 0 at a rising edge):
  - `out_valid` = 8'h00 and all `out_dataN` = 0.
  - `xfer_cnt` = 0 when compiled in.
  - Buffered words are discarded, including during a mid-stream stall.
  - `in_ready` is 1 in the first cycle after reset.

## Timing
- Latency: a word accepted at edge k is visible on `out_dataN` with `out_valid[n]` = 1 in cycle k+1. There is no combinational path from `in_data` to any output.
- Throughput: one word per cycle when destinations are not stalled, including back-to-back words to the same channel whose consumer holds `out_ready` high.
- Word loss: none. A FULL channel is never overwritten unless it drains in the same cycle.

## Configuration
- Macro: `DEMUX8_CNT_EN`.
- Defined:
  - `xfer_cnt` port exists.
  - It increments by 1 on every accepted input word.
  - It wraps from 16'hFFFF to 16'h0000.
  - It resets to 0.
- Undefined:
  - Port and counter logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset then idle: after `reset_n` low for 2 cycles, `out_valid` = 8'h00, all `out_dataN` = 0, `in_ready` = 1, `xfer_cnt` = 0.
- Single delivery:
  - Stimulus: `slt` = 3'd5, `in_data` = 32'hDEADBEEF, `in_valid` = 1 for one cycle, `out_ready` = 0.
  - Response: next cycle `out_valid` = 8'h20 and `out_data5` = 32'hDEADBEEF. After `out_ready[5]` = 1 for one cycle, `out_valid` = 8'h00.
- Backpressure:
  - Stimulus: channel 2 FULL with `out_ready[2]` = 0; present `slt` = 2 with 32'h1.
  - Response: `in_ready` = 0 and `out_data2` is unchanged.
  - Then, with `slt` = 3 and no other change, `in_ready` = 1 and the word lands in `out_data3`.
- Pass-through refill:
  - Stimulus: channel 0 FULL with 32'hA; in the same cycle `out_ready[0]` = 1 and an input to `slt` = 0 with 32'hB.
  - Response: `in_ready` = 1, next cycle `out_valid[0]` = 1 and `out_data0` = 32'hB.
- Streaming all channels:
  - Stimulus: 8 consecutive words, `slt` = 0..7, data = 32'h100+n, all `out_ready` = 0.
  - Response: all accepted, `out_valid` = 8'hFF, each `out_dataN` = 32'h100+n, `xfer_cnt` = 8.
  - Then `reset_n` low for one cycle: `out_valid` = 8'h00.
- Counter wrap (`DEMUX8_CNT_EN` defined): after 65536 accepted words, `xfer_cnt` = 0.
